// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Transmit-side controller for the memory-mapped UART. After reset it programs
// the UART clock divider, then shares the transmitter between two byte-stream
// requesters using round-robin arbitration. Every accepted byte is sent as a
// STATUS poll (repeated until the UART reports tx ready) followed by a single
// DATA write.
//
// Parameters
//   CLK_DIV_RESET  divider written to CLK_DIV on reset exit
//   UART_BASE      UART register base address
//
// Ports
//   clk                   system clock, all state on posedge
//   reset_n               asynchronous active-low reset
//   req_valid_in[1:0]     per-requester byte valid
//   req_data_in[15:0]     requester i byte on [8i+7:8i]
//   req_ready_out[1:0]    per-requester accept (transfer on valid & ready)
//   cfg_div_in[31:0]      new divider value
//   cfg_load_in           one-cycle pulse: reprogram CLK_DIV with cfg_div_in
//   busy_out              high whenever the controller is not idle
//   tx_count_out[15:0]    bytes written to UART DATA (wrapping)
//   uart_address_out      UART register address (base + offset)
//   uart_sel_out          UART select
//   uart_read_out         UART read strobe
//   uart_write_mask_out   UART byte write mask
//   uart_write_value_out  UART write data
//   uart_read_value_in    UART combinational read data
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [31:0] CLK_DIV_RESET = 32'd434,
    parameter logic [63:0] UART_BASE     = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid_in,
    input  logic [15:0] req_data_in,
    output logic [1:0]  req_ready_out,
    input  logic [31:0] cfg_div_in,
    input  logic        cfg_load_in,
    output logic        busy_out,
    output logic [15:0] tx_count_out,
    output logic [63:0] uart_address_out,
    output logic        uart_sel_out,
    output logic        uart_read_out,
    output logic [3:0]  uart_write_mask_out,
    output logic [63:0] uart_write_value_out,
    input  logic [63:0] uart_read_value_in
);

    // UART register map
    localparam logic [63:0] OFF_CLK_DIV = 64'h0;
    localparam logic [63:0] OFF_STATUS  = 64'h4;
    localparam logic [63:0] OFF_DATA    = 64'h8;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_POLL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        cfg_pending_q, cfg_pending_d;
    logic [31:0] div_q, div_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] tx_count_q, tx_count_d;
    logic [7:0]  tx_byte_q, tx_byte_d;

    // ------------------------------------------------------------------
    // Combinational controls
    // ------------------------------------------------------------------
    logic        cfg_clear;
    logic        accept;
    logic        grant_any;
    logic        grant_idx;
    logic [1:0]  ready_c;
    logic        busy_c;
    logic        sel_c;
    logic        read_c;
    logic [3:0]  mask_c;
    logic [63:0] addr_c;
    logic [63:0] value_c;

    // Only bit0 of STATUS carries meaning for this block.
    logic        unused_read_bits;
    assign unused_read_bits = ^uart_read_value_in[63:1];

    // Split the packed requester data into one byte per requester.
    logic [7:0] req_byte [2];
    for (genvar gi = 0; gi < 2; gi++) begin : g_req_split
        assign req_byte[gi] = req_data_in[8*gi +: 8];
    end

    // ------------------------------------------------------------------
    // Round-robin grant: a lone requester always wins; when both are
    // valid, the one that did not win last time is chosen.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = |req_valid_in;
        grant_idx = last_grant_q;
        case (req_valid_in)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant_q;
            default: grant_idx = last_grant_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and bus decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        tx_byte_d    = tx_byte_q;
        last_grant_d = last_grant_q;
        tx_count_d   = tx_count_q;
        cfg_clear    = 1'b0;
        accept       = 1'b0;
        busy_c       = 1'b1;
        sel_c        = 1'b0;
        read_c       = 1'b0;
        mask_c       = 4'b0000;
        addr_c       = UART_BASE;
        value_c      = 64'h0;

        case (state_q)
            ST_CFG: begin
                sel_c     = 1'b1;
                addr_c    = UART_BASE + OFF_CLK_DIV;
                mask_c    = 4'b0011;
                value_c   = {32'b0, div_q};
                cfg_clear = 1'b1;
                state_d   = ST_IDLE;
            end

            ST_IDLE: begin
                busy_c = 1'b0;
                // A pending reconfiguration is served before any new grant.
                if (cfg_pending_q) begin
                    state_d = ST_CFG;
                end else if (grant_any) begin
                    accept       = 1'b1;
                    tx_byte_d    = req_byte[grant_idx];
                    last_grant_d = grant_idx;
                    state_d      = ST_POLL;
                end
            end

            ST_POLL: begin
                sel_c  = 1'b1;
                read_c = 1'b1;
                addr_c = UART_BASE + OFF_STATUS;
                // STATUS is combinational, so the decision uses this
                // cycle's read data; no timeout by design.
                if (uart_read_value_in[0]) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                sel_c      = 1'b1;
                addr_c     = UART_BASE + OFF_DATA;
                mask_c     = 4'b0001;
                value_c    = {56'b0, tx_byte_q};
                tx_count_d = tx_count_q + 16'd1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_CFG;
            end
        endcase
    end

    // One-hot ready toward the granted requester, only on an accept cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_c[gi] = accept && (grant_idx == gi[0]);
    end

    // ------------------------------------------------------------------
    // Divider / reconfiguration request. A load pulse always wins over the
    // clear from CFG so that a request arriving during CFG is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_pending_d = cfg_pending_q;
        div_d         = div_q;
        if (cfg_load_in) begin
            cfg_pending_d = 1'b1;
            div_d         = cfg_div_in;
        end else if (cfg_clear) begin
            cfg_pending_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_CFG;
            cfg_pending_q <= 1'b0;
            div_q         <= CLK_DIV_RESET;
            last_grant_q  <= 1'b1;
            tx_count_q    <= 16'h0;
            tx_byte_q     <= 8'h0;
        end else begin
            state_q       <= state_d;
            cfg_pending_q <= cfg_pending_d;
            div_q         <= div_d;
            last_grant_q  <= last_grant_d;
            tx_count_q    <= tx_count_d;
            tx_byte_q     <= tx_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The state register holds CFG during reset, so the bus
    // decode is gated to keep every output quiet while reset_n is low.
    // ------------------------------------------------------------------
    assign req_ready_out        = reset_n ? ready_c : 2'b00;
    assign busy_out             = reset_n & busy_c;
    assign uart_sel_out         = reset_n & sel_c;
    assign uart_read_out        = reset_n & read_c;
    assign uart_write_mask_out  = reset_n ? mask_c : 4'b0000;
    assign uart_address_out     = reset_n ? addr_c : 64'h0;
    assign uart_write_value_out = reset_n ? value_c : 64'h0;
    assign tx_count_out         = tx_count_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Transmit-side controller for the memory-mapped `uart` peripheral. It programs the UART clock divider after reset and on request. It then shares the UART transmitter between two byte-stream requesters with round-robin arbitration. Each accepted byte is sequenced as a STATUS poll followed by a DATA write on the UART's register port. It sits between the UART and its producers (CPU console path, debug/boot monitor) in place of a direct bus connection for TX traffic.

## Interface
- `CLK_DIV_RESET`, default 32'd434: divider written to CLK_DIV on reset exit.
- `UART_BASE`, default 64'h0: UART register base address.

Ports:
- `clk`  in  1  system clock; all logic rises on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid_in`  in  2  per-requester byte valid; bit i = requester i.
- `req_data_in`  in  16  requester i byte on [8i+7:8i].
- `req_ready_out`  out  2  per-requester accept; transfer when valid & ready.
- `cfg_div_in`  in  32  new divider value.
- `cfg_load_in`  in  1  one-cycle pulse: reprogram CLK_DIV with `cfg_div_in`.
- `busy_out`  out  1  high in any state other than IDLE.
- `tx_count_out`  out  16  bytes written to UART DATA; wraps 16'hFFFF→0.
- `uart_address_out`  out  64  UART_BASE + register offset.
- `uart_sel_out`  out  1  UART select.
- `uart_read_out`  out  1  UART read strobe.
- `uart_write_mask_out`  out  4  UART write mask.
- `uart_write_value_out`  out  64  UART write data.
- `uart_read_value_in`  in  64  UART combinational read data.

## Operation
- UART register offsets are fixed: CLK_DIV 0x0, STATUS 0x4, DATA 0x8. STATUS bit0 = tx ready.
- The FSM has four states: CFG, IDLE, POLL, WRITE. Bus outputs decode combinationally from state. In any state not listed below, sel, read and mask are all 0.
- CFG: sel=1, addr=BASE+0x0, mask=4'b0011, value={32'b0, div_reg}. Next state is IDLE. `div_reg` resets to CLK_DIV_RESET.
- IDLE with `cfg_pending` set: go to CFG. `req_ready_out` = 0.
- IDLE otherwise, choose the grant:
  - Only one valid requester: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - `req_ready_out[g]` = 1 combinationally for the granted requester only.
  - On acceptance, latch the byte into `tx_byte`, set `last_grant`←g, and go to POLL.
- POLL: sel=1, read=1, addr=BASE+0x4.
  - `uart_read_value_in[0]`=1: go to WRITE.
  - Otherwise stay in POLL. There is no timeout.
- WRITE: sel=1, addr=BASE+0x8, mask=4'b0001, value={48'b0, 8'b0, tx_byte}. Increment `tx_count_out`, then go to IDLE.
- `cfg_load_in` sets `cfg_pending` and loads `div_reg`←`cfg_div_in`, in any state. CFG clears `cfg_pending`.
  - A new `cfg_load_in` pulse in the same cycle as CFG takes precedence: `cfg_pending` stays set and `div_reg` updates.
  - A reconfiguration never interrupts POLL or WRITE. It takes effect at the next IDLE, before any new grant.
- Requester data is sampled only on the accept cycle. Changes to `req_data_in` afterwards have no effect on the byte in flight.

## Timing
- Reset (`reset_n`=0) is asynchronous. It forces:
  - state=CFG, `cfg_pending`=0, `last_grant`=1, `tx_count_out`=0, `div_reg`=CLK_DIV_RESET, `tx_byte`=0.
  - Outputs while reset is low: `req_ready_out`=0, `busy_out`=0, `uart_sel_out`=0, read=0, mask=0, `uart_address_out`=0, `uart_write_value_out`=0.
- The first cycle after reset release is CFG. The earliest accept is the 2nd cycle after release.
- Reset asserted mid-transfer discards the in-flight byte. No partial DATA write is issued after reset.
- A byte accepted at cycle T has POLL at T+1. With UART ready, WRITE is at T+2 and IDLE at T+3.
- Peak throughput is one byte per 3 cycles. Continuous dual traffic alternates 0,1,0,1.
- STATUS is evaluated in the same cycle it is read. The UART's busy state after a DATA write is therefore visible at the next POLL; no extra wait state is needed.
- `tx_count_out` updates on the clock edge ending WRITE.

## Test plan
- Reset release with default parameters → exactly one cycle of sel=1, addr=0x0, mask=4'b0011, value=434; then IDLE with `busy_out`=0.
- Requester 0 sends 8'h41 and STATUS returns 1 → ready0 high for 1 cycle. POLL on the next cycle, then WRITE at addr 0x8 with value 64'h41 and mask 4'b0001. `tx_count_out`=1.
- Both requesters hold valid with data 8'hA0 and 8'hB1 → UART writes appear in order A0, B1, A0, B1. Requester 1 sees no ready while requester 0 is in flight.
- STATUS forced to 0 for 10 cycles then 1 → 10 POLL cycles, no DATA write during them. WRITE happens the cycle after bit0 rises. `busy_out` stays high throughout.
- `cfg_load_in` with div=32'd27 pulsed during POLL while requester 1 is valid → WRITE completes first. CFG then writes 27, and only after that does requester 1 get ready.
- `reset_n` pulsed low during POLL → all UART outputs immediately 0 and `tx_count_out`=0. After release, CFG writes 434 again and there is no stale DATA write.
